// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch sequencer that sits between a 1-cycle registered
// instruction memory and the decode stage.
//
// A word-indexed fetch PC drives the memory. Each returned word is paired with
// the PC that requested it and queued in a 2-entry in-order buffer. Decode
// takes entries from that buffer over a valid/ready handshake.
//
// A new fetch is issued only if the buffer is sure to have room for it when
// its data comes back. That check counts buffered entries plus the read still
// in flight, minus the entry decode takes this cycle, so the buffer can never
// overflow.
//
// A redirect does four things in the cycle it is asserted:
//   - completes any handshake happening in that cycle,
//   - flushes the entries left in the buffer,
//   - drops the read returning in that cycle,
//   - loads the target PC, with no issue in that cycle.
// Because nothing is issued while a redirect is asserted, no stale read can
// still be in flight afterwards, so no separate squash flag is kept.
//
// When the fetch PC is outside 0..MEM_DEPTH-1, fault is raised and issue
// stops. Entries already in the buffer still drain. Only reset or a redirect
// to an in-range PC clears fault.
//
// Ports:
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous, active-high reset
//   imem_pc         out  32  word index presented to instruction memory
//   imem_inst       in   32  memory data, valid the cycle after imem_pc sampled
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  redirect target word index
//   out_valid       out  1   instruction available to decode
//   out_ready       in   1   decode accepts this cycle
//   out_inst        out  32  head instruction word
//   out_pc          out  32  word index of out_inst
//   fault           out  1   fetch PC out of range; fetch halted
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int          MEM_DEPTH = 128,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH);

  // Fetch-side state.
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q,   req_pc_d;
  logic        inflight_q, inflight_d;

  // Two-entry output buffer, addressed by 1-bit read/write pointers.
  logic [31:0] ent_inst_q [2];
  logic [31:0] ent_pc_q   [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q,  count_d;

  // Per-cycle control.
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ_after;

  // The memory address always follows the fetch register.
  assign imem_pc   = fetch_pc_q;

  // fault depends only on the fetch register.
  assign fault     = (fetch_pc_q >= PC_LIMIT);

  // The outputs always show the head entry.
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = ent_inst_q[rd_ptr_q];
  assign out_pc    = ent_pc_q[rd_ptr_q];

  always_comb begin
    pop       = out_valid && out_ready;
    // A read returning in a redirect cycle belongs to the old path.
    push      = inflight_q && !redirect_valid;
    // out_valid implies count_q >= 1, so this subtraction cannot underflow.
    occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = !redirect_valid && !fault && (occ_after <= 3'd1);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      // The target is a word index and is used exactly as given.
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
      req_pc_d   = fetch_pc_q;
    end

    if (redirect_valid) begin
      // A pop in this cycle still counts as accepted. Whatever is left in
      // the buffer belongs to the old path and is discarded.
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ent_inst_q[i] <= 32'd0;
        ent_pc_q[i]   <= 32'd0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        ent_inst_q[wr_ptr_q] <= imem_inst;
        ent_pc_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.MEM_DEPTH(128), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each memory word has a distinct, recognisable value.
  function automatic logic [31:0] word_at(input logic [31:0] idx);
    return 32'hA500_0000 | (idx & 32'h0000_FFFF);
  endfunction

  // 1-cycle registered instruction memory.
  always @(posedge clk) imem_inst <= word_at(imem_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the head of the output. When v is set, also check its pc and word.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".pc"},   out_pc,   pc);
      chk({tag, ".inst"}, out_inst, word_at(pc));
    end
  endtask

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    tick();

    // c0: state after reset; release reset here.
    chk("rst.valid",   {31'd0, out_valid}, 32'd0);
    chk("rst.fault",   {31'd0, fault},     32'd0);
    chk("rst.out_pc",  out_pc,   32'd0);
    chk("rst.out_inst", out_inst, 32'd0);
    chk("rst.imem_pc", imem_pc,  32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;

    tick(); expect_out("c1", 1'b0, 32'd0);
    tick(); expect_out("c2", 1'b1, 32'd0);
    tick(); expect_out("c3", 1'b1, 32'd1);
    tick(); expect_out("c4", 1'b1, 32'd2);
    out_ready = 1'b0;

    // Backpressure: the head holds and issue stops once the buffer is full.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("hold", 1'b1, 32'd2);
      chk("hold.imem_pc", imem_pc, 32'd4);
    end
    tick(); expect_out("c8", 1'b1, 32'd2);
    out_ready = 1'b1;
    tick(); expect_out("c9",  1'b1, 32'd3);
    tick(); expect_out("c10", 1'b1, 32'd4);
    tick(); expect_out("c11", 1'b1, 32'd5);
    // Redirect in the same cycle that entry 5 is accepted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd40;

    tick(); expect_out("c12", 1'b0, 32'd0);
    redirect_valid = 1'b0;
    tick(); expect_out("c13", 1'b0, 32'd0);
    tick(); expect_out("c14", 1'b1, 32'd40);
    tick(); expect_out("c15", 1'b1, 32'd41);
    tick(); expect_out("c16", 1'b1, 32'd42);
    out_ready = 1'b0;
    tick(); expect_out("c17", 1'b1, 32'd42);
    // Redirect while the buffer is full and stalled.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd5;

    tick(); expect_out("c18", 1'b0, 32'd0);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick(); expect_out("c19", 1'b0, 32'd0);
    tick(); expect_out("c20", 1'b1, 32'd5);
    tick(); expect_out("c21", 1'b1, 32'd6);
    // Two redirects in a row; the second one takes effect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd60;
    tick(); expect_out("c22", 1'b0, 32'd0);
    redirect_pc    = 32'd126;
    tick(); expect_out("c23", 1'b0, 32'd0);
    redirect_valid = 1'b0;
    tick(); expect_out("c24", 1'b0, 32'd0);
    chk("c24.fault", {31'd0, fault}, 32'd0);
    tick(); expect_out("c25", 1'b1, 32'd126);
    chk("c25.fault", {31'd0, fault}, 32'd1);
    tick(); expect_out("c26", 1'b1, 32'd127);
    tick(); expect_out("c27", 1'b0, 32'd0);
    chk("c27.fault", {31'd0, fault}, 32'd1);
    tick(); expect_out("c28", 1'b0, 32'd0);
    chk("c28.imem_pc", imem_pc, 32'd128);
    // Leave the fault state by redirecting to an in-range PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd3;

    tick();
    redirect_valid = 1'b0;
    chk("c29.fault", {31'd0, fault}, 32'd0);
    expect_out("c29", 1'b0, 32'd0);
    tick(); expect_out("c30", 1'b0, 32'd0);
    tick(); expect_out("c31", 1'b1, 32'd3);
    out_ready = 1'b0;
    tick(); expect_out("c32", 1'b1, 32'd3);
    tick(); expect_out("c33", 1'b1, 32'd3);
    // Reset while the buffer is full.
    reset = 1'b1;

    tick();
    chk("mrst.valid",   {31'd0, out_valid}, 32'd0);
    chk("mrst.fault",   {31'd0, fault},     32'd0);
    chk("mrst.out_pc",  out_pc,   32'd0);
    chk("mrst.out_inst", out_inst, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick(); expect_out("c35", 1'b0, 32'd0);
    tick(); expect_out("c36", 1'b1, 32'd0);
    tick(); expect_out("c37", 1'b1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
